// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample stream, coefficient ROM and result bundle for the serial FIR engine
interface fir_serial_mac_if;
    logic signed [15:0] din;
    logic               in_valid;
    logic               in_ready;
    logic               tone_sel;
    logic [5:0]         coef_addr;
    logic               coef_sel;
    logic signed [15:0] coef_data;
    logic signed [15:0] dout;
    logic               dout_valid;
    modport master (
        output din, in_valid, tone_sel, coef_data,
        input  in_ready, coef_addr, coef_sel, dout, dout_valid
    );
    modport slave (
        input  din, in_valid, tone_sel, coef_data,
        output in_ready, coef_addr, coef_sel, dout, dout_valid
    );
endinterface

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: single-multiplier 64-tap FIR; FIR_SAT_EN selects output saturation instead of wrap
module fir_serial_mac #(
    parameter int SHIFT = 15,
    parameter int ACC_W = 38
) (
    input logic             clk,
    input logic             rst,
    fir_serial_mac_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;
    state_t                  state, state_n;
    logic signed [15:0]      hist [64];
    logic [5:0]              ptr, tap, rd;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc, acc_sum, acc_rnd;
    logic signed [15:0]      y, dout_r;
    logic                    sel;
`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] acc_sh;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state, handshake and ROM drive
    always_comb begin
        state_n = state == IDLE  ? (bus.in_valid ? MAC : IDLE) :
                  state == MAC   ? (tap == 6'd63 ? DRAIN : MAC) :
                  state == DRAIN ? OUT : IDLE;
        bus.in_ready   = state == IDLE;
        bus.dout_valid = state == OUT;
        bus.coef_addr  = state == MAC ? tap : 6'd0;
        bus.coef_sel   = sel;
        bus.dout       = dout_r;
    end
    // tap read address walks backwards from the newest sample; rounding and output reduction
    always_comb begin
        rd      = ptr - 6'd1 - tap;
        acc_sum = acc + ACC_W'(prod);
        acc_rnd = acc_sum + (ACC_W'(1) << (SHIFT - 1));
`ifdef FIR_SAT_EN
        acc_sh  = acc_rnd >>> SHIFT;
        y       = acc_sh > ACC_W'(32767)  ? 16'sh7fff :
                  acc_sh < -ACC_W'(32768) ? 16'sh8000 : acc_sh[15:0];
`else
        y       = 16'(acc_rnd >>> SHIFT);
`endif
    end
    // history write on accept, pipelined multiply-accumulate, result capture in DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) hist[i] <= '0;
            ptr    <= '0;
            tap    <= '0;
            acc    <= '0;
            prod   <= '0;
            sel    <= 1'b0;
            dout_r <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                hist[ptr] <= bus.din;
                ptr       <= ptr + 6'd1;
                sel       <= bus.tone_sel;
                acc       <= '0;
                prod      <= '0;
                tap       <= '0;
            end
            if (state == MAC) begin
                prod <= 32'(bus.coef_data) * 32'(hist[rd]);
                acc  <= acc_sum;
                tap  <= tap + 6'd1;
            end
            if (state == DRAIN) begin
                acc    <= acc_sum;
                dout_r <= y;
            end
        end
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: randomized self-checking bench against a direct convolution model
module tb_fir_serial_mac;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic signed [15:0] rom [2][64];
    int   hx [$];
    int   expv, c, bad;
    logic signed [15:0] x;

    fir_serial_mac_if b ();
    fir_serial_mac dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;
    // bench coefficient ROM, combinational like the real one
    always_comb b.coef_data = rom[b.coef_sel][b.coef_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // y = sum h[k]*x[n-k] over accepted samples since reset, rounded, shifted, reduced
    function automatic int model(input logic s);
        longint acc = 0;
        longint r;
        int n = hx.size();
        for (int k = 0; k < 64; k++)
            if (n - 1 - k >= 0) acc += longint'(rom[s][k]) * longint'(hx[n - 1 - k]);
        r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return int'(r);
`else
        return int'(shortint'(r));
`endif
    endfunction

    task automatic send(input logic signed [15:0] v, input logic s, input string tag, output int got);
        int n = 0;
        while (!b.in_ready && n < 200) begin tick; n++; end
        b.din = v; b.tone_sel = s; b.in_valid = 1'b1;
        tick;
        b.in_valid = 1'b0;
        hx.push_back(int'(v));
        n = 1;
        while (!b.dout_valid && n < 200) begin tick; n++; end
        chk({tag, "_lat"}, n, 66);
        chk(tag, b.dout, model(s));
        got = int'(b.dout);
        tick;
    endtask

    initial begin
        int got;
        rst = 1'b1; b.in_valid = 1'b0; b.din = '0; b.tone_sel = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 64; k++) rom[s][k] = 16'($urandom);
        repeat (2) tick;
        chk("rst_in_ready", b.in_ready, 1);
        chk("rst_dout", b.dout, 0);
        chk("rst_dout_valid", b.dout_valid, 0);
        chk("rst_coef_addr", b.coef_addr, 0);
        chk("rst_coef_sel", b.coef_sel, 0);
        rst = 1'b0;
        tick;
        // impulse response through set 0
        send(16'sd32767, 1'b0, "imp0", got);
        for (int i = 0; i < 63; i++) send(16'sd0, 1'b0, "imp", got);
        // continuous in_valid, tone_sel toggled during the computation
        x = 16'($urandom);
        b.din = x; b.tone_sel = 1'b1; b.in_valid = 1'b1;
        tick;
        hx.push_back(int'(x));
        expv = model(1'b1);
        bad = 0;
        for (int cy = 1; cy <= 66; cy++) begin
            if (b.in_ready !== 1'b0) bad++;
            if (b.coef_sel !== 1'b1) bad++;
            if (b.coef_addr !== (cy <= 64 ? 6'(cy - 1) : 6'd0)) bad++;
            if (b.dout_valid !== (cy == 66)) bad++;
            if (cy == 66) chk("hold_dout", b.dout, expv);
            b.tone_sel = ~b.tone_sel;
            b.din = 16'($urandom);
            tick;
        end
        chk("hold_cycle_errors", bad, 0);
        chk("hold_ready_c67", b.in_ready, 1);
        x = 16'($urandom);
        b.din = x; b.tone_sel = 1'b0;
        tick;
        b.in_valid = 1'b0;
        hx.push_back(int'(x));
        chk("second_accept", b.in_ready, 0);
        chk("sel_relatch", b.coef_sel, 0);
        c = 1;
        while (!b.dout_valid && c < 200) begin tick; c++; end
        chk("second_lat", c, 66);
        chk("second_dout", b.dout, model(1'b0));
        tick;
        // reset at cycle 30 of a computation
        b.din = 16'sd12345; b.tone_sel = 1'b0; b.in_valid = 1'b1;
        tick;
        b.in_valid = 1'b0;
        repeat (29) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        hx.delete();
        chk("midrst_ready", b.in_ready, 1);
        chk("midrst_dout", b.dout, 0);
        c = 0;
        for (int i = 0; i < 80; i++) begin
            if (b.dout_valid) c++;
            tick;
        end
        chk("midrst_no_valid", c, 0);
        // reset beats a simultaneous in_valid
        rst = 1'b1; b.in_valid = 1'b1; b.din = 16'sd777;
        tick;
        rst = 1'b0; b.in_valid = 1'b0;
        chk("rst_vs_valid", b.in_ready, 1);
        tick;
        send(16'sd32767, 1'b0, "imp2_0", got);
        for (int i = 0; i < 63; i++) send(16'sd0, 1'b0, "imp2", got);
        // random samples across pointer wrap
        for (int i = 0; i < 130; i++) send(16'($urandom), 1'($urandom), "rand", got);
        // full-scale sum through an all-32767 set
        for (int k = 0; k < 64; k++) rom[1][k] = 16'sd32767;
        for (int i = 0; i < 64; i++) send(16'sd32767, 1'b1, "sat", got);
`ifdef FIR_SAT_EN
        chk("sat_last", got, 32767);
`else
        chk("wrap_last", got, -128);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
